// File: rtl/cursor_input_controller.sv
// Cursor input controller: debounces the five board buttons, steers a one-hot
// Row/Col cursor over the 8x8 grid, and hands confirmed cell selections to the
// game logic through a valid/ack handshake. A raw centre-press pulse is also
// exported for the menu screens.
//
// Handshake (sel_valid / sel_ack): sel_valid rises on the edge after an
// accepted centre press and stays high with sel_row/sel_col frozen until the
// first rising edge on which sel_ack is sampled high; sel_valid is low in the
// following cycle. sel_ack sampled while sel_valid is low has no effect.
module cursor_input_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnC,
  input  logic       enable,
  output logic [7:0] Row,
  output logic [7:0] Col,
  output logic       btnc_pulse,
  output logic       sel_valid,
  output logic [7:0] sel_row,
  output logic [7:0] sel_col,
  input  logic       sel_ack,
  output logic       dbg_state
);

  // Button lane indices
  localparam int B_U = 0;
  localparam int B_D = 1;
  localparam int B_L = 2;
  localparam int B_R = 3;
  localparam int B_C = 4;
  localparam int NB  = 5;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } sel_state_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_stable;
  logic [NB-1:0]    r_stable_d;
  logic [NB-1:0]    r_pulse;
  logic [CNT_W-1:0] r_cnt [NB];

  sel_state_t r_state;
  sel_state_t w_state_next;
  logic       w_accept;

  logic [7:0] r_row;
  logic [7:0] r_col;
  logic [7:0] r_sel_row;
  logic [7:0] r_sel_col;

  assign w_raw = {BtnC, BtnR, BtnL, BtnD, BtnU};

  // Synchronise, debounce and edge-detect every button lane
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_pulse    <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == LP_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Selection handshake state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Selection handshake next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (r_pulse[B_C] && enable) w_state_next = S_PENDING;
      S_PENDING: if (sel_ack)                w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Selection handshake outputs; moves and captures are only honoured in IDLE
  always_comb begin
    w_accept  = (r_state == S_IDLE) && enable;
    sel_valid = (r_state == S_PENDING);
    dbg_state = r_state;
  end

  // Cursor moves and selection capture; a centre press wins over any move
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row     <= 8'h01;
      r_col     <= 8'h01;
      r_sel_row <= 8'h00;
      r_sel_col <= 8'h00;
    end else if (w_accept) begin
      if (r_pulse[B_C]) begin
        r_sel_row <= r_row;
        r_sel_col <= r_col;
      end else begin
        if (r_pulse[B_U] && !r_pulse[B_D])      r_row <= {r_row[0], r_row[7:1]};
        else if (r_pulse[B_D] && !r_pulse[B_U]) r_row <= {r_row[6:0], r_row[7]};
        if (r_pulse[B_L] && !r_pulse[B_R])      r_col <= {r_col[0], r_col[7:1]};
        else if (r_pulse[B_R] && !r_pulse[B_L]) r_col <= {r_col[6:0], r_col[7]};
      end
    end
  end

  assign Row        = r_row;
  assign Col        = r_col;
  assign sel_row    = r_sel_row;
  assign sel_col    = r_sel_col;
  assign btnc_pulse = r_pulse[B_C];

endmodule

// File: tb/tb_cursor_input_controller.sv
// Bench for cursor_input_controller with a short debounce window.
`timescale 1ns/1ps
module tb_cursor_input_controller;

  localparam int D     = 4;
  localparam int CNT_W = 4;

  // Button masks: bit0=U, bit1=D, bit2=L, bit3=R, bit4=C
  localparam logic [4:0] M_U = 5'b00001;
  localparam logic [4:0] M_D = 5'b00010;
  localparam logic [4:0] M_L = 5'b00100;
  localparam logic [4:0] M_R = 5'b01000;
  localparam logic [4:0] M_C = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0, BtnC = 1'b0;
  logic       enable = 1'b0;
  logic       sel_ack = 1'b0;
  logic [7:0] Row, Col, sel_row, sel_col;
  logic       btnc_pulse, sel_valid, dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  logic [32:0] exp_q[$];

  cursor_input_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC),
    .enable(enable),
    .Row(Row), .Col(Col),
    .btnc_pulse(btnc_pulse),
    .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col),
    .sel_ack(sel_ack),
    .dbg_state(dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count centre pulses, sampled away from the active edge
  always @(negedge clk) if (btnc_pulse === 1'b1) pulse_cnt++;

  // Driver tasks
  task automatic set_btns(input logic [4:0] m);
    {BtnC, BtnR, BtnL, BtnD, BtnU} = m;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    set_btns(5'b0);
    sel_ack = 1'b0;
    tick(n);
    reset = 1'b0;
  endtask

  // Hold the mask for 'hold' samples, then release long enough to settle
  task automatic press(input logic [4:0] m, input int hold);
    @(negedge clk);
    set_btns(m);
    tick(hold);
    set_btns(5'b0);
    tick(D + 6);
  endtask

  task automatic test_reset();
    enable = 1'b0;
    do_reset(3);
    n_cmp++; if (Row !== 8'h01)      begin n_bad++; $display("FAIL reset_row got %h exp 01", Row); end
    n_cmp++; if (Col !== 8'h01)      begin n_bad++; $display("FAIL reset_col got %h exp 01", Col); end
    n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sel_valid got %b exp 0", sel_valid); end
    n_cmp++; if (btnc_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_btnc_pulse got %b exp 0", btnc_pulse); end
    n_cmp++; if (sel_row !== 8'h00 || sel_col !== 8'h00)
      begin n_bad++; $display("FAIL reset_sel_rc got %h/%h exp 00/00", sel_row, sel_col); end
  endtask

  // Clean BtnD level from edge 0: Row moves after edge D+3, exactly one step
  task automatic test_latency();
    logic [7:0] exp_row;
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    enable = 1'b1;
    BtnD = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_row = (k >= D + 3) ? 8'h02 : 8'h01;
      n_cmp++;
      if (Row !== exp_row) begin n_bad++; $display("FAIL latency_row edge %0d got %h exp %h", k, Row, exp_row); end
    end
    BtnD = 1'b0;
    tick(D + 6);
    n_cmp++; if (Row !== 8'h02) begin n_bad++; $display("FAIL latency_single_step got %h exp 02", Row); end
  endtask

  task automatic test_wrap();
    do_reset(2);
    enable = 1'b1;
    press(M_U, 6);
    n_cmp++; if (Row !== 8'h80) begin n_bad++; $display("FAIL wrap_up got %h exp 80", Row); end
    for (int i = 0; i < 7; i++) press(M_R, 6);
    n_cmp++; if (Col !== 8'h80) begin n_bad++; $display("FAIL walk_right got %h exp 80", Col); end
    press(M_R, 6);
    n_cmp++; if (Col !== 8'h01) begin n_bad++; $display("FAIL wrap_right got %h exp 01", Col); end
    n_cmp++; if (Row !== 8'h80) begin n_bad++; $display("FAIL wrap_row_kept got %h exp 80", Row); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      BtnL = 1'b1;
      tick(3);
      BtnL = 1'b0;
    end
    tick(D + 6);
    n_cmp++; if (Col !== 8'h01) begin n_bad++; $display("FAIL bounce_ignored got %h exp 01", Col); end
    press(M_L, 10);
    n_cmp++; if (Col !== 8'h80) begin n_bad++; $display("FAIL bounce_then_hold got %h exp 80", Col); end
  endtask

  task automatic test_handshake();
    int p0;
    do_reset(2);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) press(M_D, 6);
    for (int i = 0; i < 4; i++) press(M_R, 6);
    n_cmp++; if (Row !== 8'h08 || Col !== 8'h10)
      begin n_bad++; $display("FAIL hs_setup got %h/%h exp 08/10", Row, Col); end
    p0 = pulse_cnt;
    press(M_C, 6);
    n_cmp++; if (pulse_cnt !== p0 + 1) begin n_bad++; $display("FAIL hs_pulse_cycles got %0d exp %0d", pulse_cnt - p0, 1); end
    n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL hs_valid got %b exp 1", sel_valid); end
    n_cmp++; if (sel_row !== 8'h08 || sel_col !== 8'h10)
      begin n_bad++; $display("FAIL hs_capture got %h/%h exp 08/10", sel_row, sel_col); end
    press(M_D | M_C, 6);
    n_cmp++; if (Row !== 8'h08) begin n_bad++; $display("FAIL hs_move_ignored got %h exp 08", Row); end
    n_cmp++; if (sel_row !== 8'h08 || sel_col !== 8'h10)
      begin n_bad++; $display("FAIL hs_capture_held got %h/%h exp 08/10", sel_row, sel_col); end
    n_cmp++; if (pulse_cnt !== p0 + 2) begin n_bad++; $display("FAIL hs_second_pulse got %0d exp %0d", pulse_cnt - p0, 2); end
    enable = 1'b0;
    tick(3);
    n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL hs_enable_drop got %b exp 1", sel_valid); end
    sel_ack = 1'b1;
    @(negedge clk);
    sel_ack = 1'b0;
    n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL hs_ack got %b exp 0", sel_valid); end
  endtask

  task automatic test_gating();
    int p0;
    enable = 1'b0;
    p0 = pulse_cnt;
    press(M_C | M_R, 6);
    n_cmp++; if (pulse_cnt !== p0 + 1) begin n_bad++; $display("FAIL gate_pulse got %0d exp 1", pulse_cnt - p0); end
    n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL gate_valid got %b exp 0", sel_valid); end
    n_cmp++; if (Col !== 8'h10) begin n_bad++; $display("FAIL gate_col got %h exp 10", Col); end
  endtask

  task automatic test_simultaneous();
    enable = 1'b1;
    press(M_U | M_D, 6);
    n_cmp++; if (Row !== 8'h08) begin n_bad++; $display("FAIL sim_ud got %h exp 08", Row); end
    press(M_L | M_R, 6);
    n_cmp++; if (Col !== 8'h10) begin n_bad++; $display("FAIL sim_lr got %h exp 10", Col); end
    press(M_U | M_R, 6);
    n_cmp++; if (Row !== 8'h04 || Col !== 8'h20)
      begin n_bad++; $display("FAIL sim_ur got %h/%h exp 04/20", Row, Col); end
  endtask

  task automatic test_reset_abort();
    int p0;
    enable = 1'b1;
    @(negedge clk);
    BtnR = 1'b1;
    BtnC = 1'b1;
    tick(2);
    reset = 1'b1;
    BtnR = 1'b0;
    BtnC = 1'b0;
    tick(2);
    reset = 1'b0;
    p0 = pulse_cnt;
    tick(D + 8);
    n_cmp++; if (Col !== 8'h01 || Row !== 8'h01)
      begin n_bad++; $display("FAIL abort_cursor got %h/%h exp 01/01", Row, Col); end
    n_cmp++; if (pulse_cnt !== p0 || sel_valid !== 1'b0)
      begin n_bad++; $display("FAIL abort_pulse got %0d/%b exp 0/0", pulse_cnt - p0, sel_valid); end
  endtask

  // Random presses, glitches, enables and acks against a cursor-index model
  task automatic test_random();
    int row_i, col_i, exp_p, p0, hold;
    logic pending, en, ack;
    logic [4:0] m;
    logic [7:0] srow, scol;
    logic [32:0] exp_v, got_v;
    do_reset(2);
    row_i = 0; col_i = 0; pending = 1'b0; srow = 8'h00; scol = 8'h00;
    exp_p = 0;
    p0 = pulse_cnt;
    for (int op = 0; op < 40; op++) begin
      m    = 5'($urandom_range(1, 31));
      hold = $urandom_range(1, D + 3);
      en   = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 2) == 0);
      enable = en;
      press(m, hold);
      if (hold >= D) begin
        if (m[4]) exp_p++;
        if (en && !pending) begin
          if (m[4]) begin
            srow = 8'(1 << row_i);
            scol = 8'(1 << col_i);
            pending = 1'b1;
          end else begin
            if (m[0] && !m[1]) row_i = (row_i + 7) % 8;
            if (m[1] && !m[0]) row_i = (row_i + 1) % 8;
            if (m[2] && !m[3]) col_i = (col_i + 7) % 8;
            if (m[3] && !m[2]) col_i = (col_i + 1) % 8;
          end
        end
      end
      exp_q.push_back({8'(1 << row_i), 8'(1 << col_i), pending, srow, scol});
      exp_v = exp_q.pop_front();
      got_v = {Row, Col, sel_valid, sel_row, sel_col};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL rand_state op %0d got %h exp %h", op, got_v, exp_v);
      end
      n_cmp++;
      if (pulse_cnt - p0 !== exp_p) begin
        n_bad++;
        $display("FAIL rand_pulses op %0d got %0d exp %0d", op, pulse_cnt - p0, exp_p);
      end
      if (ack) begin
        sel_ack = 1'b1;
        @(negedge clk);
        sel_ack = 1'b0;
        pending = 1'b0;
        n_cmp++;
        if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL rand_ack op %0d got %b exp 0", op, sel_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_bounce();
    test_handshake();
    test_gating();
    test_simultaneous();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
